// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types for the EX/MEM skid pipeline register.
// Revision: 1.0
`default_nettype none

package ex_mem_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;
  localparam int F3W_DEF  = 3;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic branch;
    logic memread;
    logic memwrite;
    logic flag_zero;
  } ex_mem_ctrl_t;

  localparam int CTRLW = $bits(ex_mem_ctrl_t);

  // Reference layout at default widths; the top packs the same field order.
  typedef struct packed {
    ex_mem_ctrl_t        ctrl;
    logic [XLEN_DEF-1:0] alu_result;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [REGW_DEF-1:0] rd;
    logic [F3W_DEF-1:0]  funct3;
  } ex_mem_bus_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic one-entry skid buffer with valid/ready and flush.
// Revision: 1.0
`default_nettype none

module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, consume;

  assign accept  = in_valid_i & in_ready_o;
  assign consume = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data_i;
            state_d = FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_d = in_data_i;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_data_i;
            state_d = SKID;
          end
        end
        SKID: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Both flags decode straight from the state flop, so no path from out_ready_i.
  always_comb begin
    out_valid_o = (state_q == FULL) || (state_q == SKID);
    in_ready_o  = (state_q != SKID);
    out_data_o  = main_q;
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX/MEM pipeline register with skid buffer, flush and stall counter.
// Revision: 1.0
`default_nettype none

module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int F3W  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            regwrite_i,
  input  logic            memtoreg_i,
  input  logic            branch_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic            flag_zero_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [F3W-1:0]  funct3_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            regwrite_o,
  output logic            memtoreg_o,
  output logic            branch_o,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            flag_zero_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [REGW-1:0] rd_o,
  output logic [F3W-1:0]  funct3_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam int BUSW = CTRLW + 2 * XLEN + REGW + F3W;

  ex_mem_ctrl_t    in_ctrl, out_ctrl;
  logic [BUSW-1:0] in_bus, out_bus;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  assign in_ctrl = '{regwrite:  regwrite_i,
                     memtoreg:  memtoreg_i,
                     branch:    branch_i,
                     memread:   memread_i,
                     memwrite:  memwrite_i,
                     flag_zero: flag_zero_i};
  assign in_bus = {in_ctrl, alu_result_i, rs2_data_i, rd_i, funct3_i};

  pipe_skid_buf #(
    .W(BUSW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_bus),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_bus)
  );

  assign {out_ctrl, alu_result_o, rs2_data_o, rd_o, funct3_o} = out_bus;

  // Side-effecting controls are masked so a bubble can never write state.
  assign regwrite_o  = out_ctrl.regwrite & out_valid_o;
  assign memread_o   = out_ctrl.memread  & out_valid_o;
  assign memwrite_o  = out_ctrl.memwrite & out_valid_o;
  assign branch_o    = out_ctrl.branch   & out_valid_o;
  assign memtoreg_o  = out_ctrl.memtoreg;
  assign flag_zero_o = out_ctrl.flag_zero;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire
